// File: rtl/stage_permutation_cfg.sv
// Frame-based lane permutation: output lane i takes input lane i with bits 0 and k swapped.
// state | meaning:  IDLE | waiting for a frame-start beat;  RUN | inside a frame, counting beats
module stage_permutation_cfg #(
   parameter int DATA_WIDTH_PER_INPUT = 28,
   parameter int INPUT_PER_CYCLE = 64,
   parameter int FRAME_CYCLES = 16,
   localparam int LOG_P = $clog2(INPUT_PER_CYCLE),
   localparam int SEL_W = $clog2(LOG_P),
   localparam int DW = INPUT_PER_CYCLE * DATA_WIDTH_PER_INPUT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_start,
   input  logic             in_valid,
   input  logic [SEL_W-1:0] stage_sel,
   input  logic [DW-1:0]    inData,
   output logic [DW-1:0]    outData,
   output logic             out_valid,
   output logic             out_start,
   output logic             frame_done,
   output logic             sel_err
);
   localparam int W = DATA_WIDTH_PER_INPUT;
   localparam int CNT_W = $clog2(FRAME_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [SEL_W:0] LOG_P_S = (SEL_W + 1)'(LOG_P);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [SEL_W-1:0] active_sel, active_sel_nx;
   logic [SEL_W-1:0] beat_sel;
   logic [DW-1:0]    perm_data, data_q, data_nx;
   logic             valid_q, valid_nx;
   logic             start_q, start_nx;
   logic             done_q, done_nx;
   logic             err_q, err_nx;
   logic             start_beat, bad_sel;

   // out-of-range selects (k >= LOG_P) fall back to identity
   function automatic logic [LOG_P-1:0] src_lane(input logic [LOG_P-1:0] i,
                                                 input logic [SEL_W-1:0] k);
      logic [LOG_P-1:0] j;
      j = i;
      if (k != '0 && {1'b0, k} < LOG_P_S) begin
         j[0] = i[k];
         j[k] = i[0];
      end
      return j;
   endfunction

   assign start_beat = in_valid & in_start;
   assign bad_sel    = !({1'b0, stage_sel} < LOG_P_S);
   assign beat_sel   = in_start ? stage_sel : active_sel;

   always_comb begin
      perm_data = '0;
      for (int i = 0; i < INPUT_PER_CYCLE; i++) begin
         perm_data[i*W +: W] = inData[32'(src_lane(LOG_P'(i), beat_sel))*W +: W];
      end
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      active_sel_nx = active_sel;
      data_nx       = data_q;
      valid_nx      = 1'b0;
      start_nx      = 1'b0;
      done_nx       = 1'b0;
      err_nx        = 1'b0;
      if (start_beat) begin
         // a start inside a running frame aborts it and is flagged as an error
         state_nx      = RUN;
         cnt_nx        = CNT_W'(1);
         active_sel_nx = stage_sel;
         data_nx       = perm_data;
         valid_nx      = 1'b1;
         start_nx      = 1'b1;
         err_nx        = bad_sel | (state == RUN);
      end else if (in_valid && state == RUN) begin
         data_nx  = perm_data;
         valid_nx = 1'b1;
         if (cnt == CNT_LAST) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
            cnt_nx   = '0;
         end else begin
            cnt_nx = cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         active_sel <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         active_sel <= active_sel_nx;
         data_q     <= data_nx;
         valid_q    <= valid_nx;
         start_q    <= start_nx;
         done_q     <= done_nx;
         err_q      <= err_nx;
      end
   end

   assign outData    = data_q;
   assign out_valid  = valid_q;
   assign out_start  = start_q;
   assign frame_done = done_q;
   assign sel_err    = err_q;
endmodule

// File: tb/tb_stage_permutation_cfg.sv
// Scoreboard bench for stage_permutation_cfg: directed frame scenarios plus randomized traffic.
module tb_stage_permutation_cfg;
   localparam int W = 28;
   localparam int P = 64;
   localparam int FRAME = 16;
   localparam int LOG_P = 6;
   localparam int DW = P * W;

   typedef struct {
      logic [DW-1:0] data;
      logic start;
      logic done;
      logic err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_start = 1'b0;
   logic          in_valid = 1'b0;
   logic [2:0]    stage_sel = '0;
   logic [DW-1:0] inData = '0;
   logic [DW-1:0] outData;
   logic          out_valid, out_start, frame_done, sel_err;

   exp_t          q[$];
   logic [DW-1:0] last_data = '0;
   int            errors = 0;
   int            checks = 0;
   bit            in_frame = 0;
   int            nbeats = 0;
   int            cur_k = 0;

   stage_permutation_cfg #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(P), .FRAME_CYCLES(FRAME)) dut (
      .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_valid(in_valid),
      .stage_sel(stage_sel), .inData(inData), .outData(outData),
      .out_valid(out_valid), .out_start(out_start), .frame_done(frame_done), .sel_err(sel_err));

   always #5 clk = ~clk;

   // output lane i reads input lane i with bits 0 and k exchanged (identity for k=0 or k>=LOG_P)
   function automatic logic [DW-1:0] model_perm(input logic [DW-1:0] d, input int k);
      logic [DW-1:0] r;
      int j, b0, bk;
      r = '0;
      for (int i = 0; i < P; i++) begin
         j = i;
         if (k >= 1 && k < LOG_P) begin
            b0 = i % 2;
            bk = (i >> k) % 2;
            j = i - b0 - bk * (1 << k) + bk + b0 * (1 << k);
         end
         r[i*W +: W] = d[j*W +: W];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] idx_data();
      logic [DW-1:0] d;
      for (int i = 0; i < P; i++) d[i*W +: W] = W'(i);
      return d;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < P; i++) d[i*W +: W] = W'($urandom);
      return d;
   endfunction

   task automatic cmp_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      checks++;
      for (int i = 0; i < P; i++) begin
         if (act[i*W +: W] !== expv[i*W +: W]) begin
            errors++;
            $display("FAIL %s: lane %0d actual %h required %h", name, i, act[i*W +: W], expv[i*W +: W]);
            break;
         end
      end
   endtask

   task automatic cmp_bits(input string name, input logic [3:0] act, input logic [3:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: actual %b required %b", name, act, expv);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: actual out_valid=1 required out_valid=0");
            end else begin
               e = q.pop_front();
               cmp_data("beat_data", outData, e.data);
               cmp_bits("beat_flags(start,done,err)", {1'b0, out_start, frame_done, sel_err},
                        {1'b0, e.start, e.done, e.err});
            end
            last_data = outData;
         end else begin
            cmp_bits("idle_flags(start,done,err)", {1'b0, out_start, frame_done, sel_err}, 4'b0);
            cmp_data("idle_hold", outData, last_data);
         end
      end
   end

   task automatic beat(input bit v, input bit s, input int k, input logic [DW-1:0] d);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = v;
      in_start = s;
      stage_sel = s ? 3'(k) : 3'($urandom_range(0, 7));
      inData = d;
      if (v && s) begin
         e.err = in_frame || (k >= LOG_P);
         in_frame = 1;
         nbeats = 1;
         cur_k = k;
         e.start = 1;
         e.done = 0;
         e.data = model_perm(d, k);
         q.push_back(e);
      end else if (v && in_frame) begin
         nbeats++;
         e.start = 0;
         e.err = 0;
         e.done = (nbeats == FRAME);
         e.data = model_perm(d, cur_k);
         if (e.done) in_frame = 0;
         q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 0;
      in_valid = 0;
      in_start = 0;
      #1;
      cmp_bits("reset_flags(valid,start,done,err)", {out_valid, out_start, frame_done, sel_err}, 4'b0);
      cmp_data("reset_data", outData, '0);
      q.delete();
      in_frame = 0;
      nbeats = 0;
      last_data = '0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1;
   endtask

   initial begin
      int tbl[16] = '{0, 8, 2, 10, 4, 12, 6, 14, 1, 9, 3, 11, 5, 13, 7, 15};
      logic [DW-1:0] idx;
      bit ok;
      bit v, s;
      idx = idx_data();
      #2;
      do_reset();

      // k=3 on lane-index data, with a known lane pattern
      beat(1, 1, 3, idx);
      beat(0, 0, 0, idx);
      @(negedge clk);
      ok = 1;
      for (int g = 0; g < 4; g++)
         for (int i = 0; i < 16; i++)
            if (outData[(g*16+i)*W +: W] !== W'(tbl[i] + 16*g)) ok = 0;
      cmp_bits("k3_lane_pattern", {3'b0, ok}, 4'b1);
      for (int b = 2; b <= FRAME; b++) beat(1, 0, 0, rand_data());

      // k=1 frame with a stall on beats 5-7
      beat(1, 1, 1, rand_data());
      for (int b = 2; b <= 4; b++) beat(1, 0, 0, rand_data());
      repeat (3) beat(0, 0, 0, rand_data());
      for (int b = 5; b <= FRAME; b++) beat(1, 0, 0, rand_data());

      // out-of-range select
      beat(1, 1, 7, idx);
      for (int b = 2; b <= FRAME; b++) beat(1, 0, 0, rand_data());

      // abort with a new start at beat 9
      beat(1, 1, 2, rand_data());
      for (int b = 2; b <= 8; b++) beat(1, 0, 0, rand_data());
      beat(1, 1, 5, rand_data());
      for (int b = 2; b <= FRAME; b++) beat(1, 0, 0, rand_data());

      // reset at beat 6, then a non-start beat must be dropped
      beat(1, 1, 4, rand_data());
      for (int b = 2; b <= 5; b++) beat(1, 0, 0, rand_data());
      do_reset();
      beat(1, 0, 0, rand_data());
      beat(0, 0, 0, rand_data());
      beat(1, 1, 0, rand_data());
      for (int b = 2; b <= FRAME; b++) beat(1, 0, 0, rand_data());

      for (int n = 0; n < 10000; n++) begin
         v = ($urandom_range(0, 9) < 8);
         s = v && (in_frame ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0));
         beat(v, s, int'($urandom_range(0, 7)), rand_data());
      end

      repeat (3) beat(0, 0, 0, '0);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_beats: actual %0d pending required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
